// File: rtl/oser10_ctrl_pkg.sv
// oser10_ctrl_pkg: shared types and constants for the OSER10 link sequencer.
package oser10_ctrl_pkg;

   // Width of the state counter and the underflow counter
   localparam int CNT_W = 16;

   // Default link words (bit 0 goes out first)
   localparam logic [9:0] TRAIN_WORD_DEF = 10'b1111100000;
   localparam logic [9:0] IDLE_WORD_DEF  = 10'b1101010100;

   // PRBS7 seed loaded on entry to run and on each PRBS_MODE rise
   localparam logic [6:0] PRBS_SEED = 7'h7F;

   typedef enum logic [1:0] {
      S_HOLD,
      S_WAIT,
      S_TRAIN,
      S_RUN
   } state_t;

endpackage

// File: rtl/oser10_prbs7.sv
// oser10_prbs7: PRBS7 (x^7+x^6+1) generator producing 10 bits per cycle.
// word[0] is the first bit of the sequence in each step, so it is the
// bit that leaves the serializer first.
module oser10_prbs7
   import oser10_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       adv,
   output logic [9:0] word
);

   logic [6:0] lfsr;
   logic [6:0] lfsr_nxt;

   // Unroll ten LFSR steps: each step emits the feedback bit and shifts it in
   always_comb begin
      logic [6:0] s;
      logic       fb;
      s    = lfsr;
      fb   = 1'b0;
      word = '0;
      for (int i = 0; i < 10; i++) begin
         fb      = s[6] ^ s[5];
         word[i] = fb;
         s       = {s[5:0], fb};
      end
      lfsr_nxt = s;
   end

   // LFSR state: seed load has priority over advance
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr <= PRBS_SEED;
      end else if (load) begin
         lfsr <= PRBS_SEED;
      end else if (adv) begin
         lfsr <= lfsr_nxt;
      end
   end

endmodule

// File: rtl/oser10_ctrl.sv
// oser10_ctrl: link sequencer in front of an OSER10 10:1 serializer.
// Holds the serializer in reset, lets it settle, sends a training burst, then
// streams source words with idle insertion on underflow.
// Optional feature: define OSER10_CTRL_PRBS_EN to add the PRBS_MODE port and
// a PRBS7 test-pattern generator usable in the run state.
module oser10_ctrl
   import oser10_ctrl_pkg::*;
#(
   parameter int         RST_CYCLES  = 16,
   parameter int         WAIT_CYCLES = 4,
   parameter int         TRAIN_WORDS = 64,
   parameter logic [9:0] TRAIN_WORD  = TRAIN_WORD_DEF,
   parameter logic [9:0] IDLE_WORD   = IDLE_WORD_DEF
) (
   input  logic              PCLK,
   input  logic              RESET,
   input  logic              ENABLE,
   input  logic              RETRAIN,
   input  logic [9:0]        DATA,
   input  logic              DATA_VLD,
   output logic              DATA_RDY,
`ifdef OSER10_CTRL_PRBS_EN
   input  logic              PRBS_MODE,
`endif
   output logic              OSER_RST,
   output logic [9:0]        OSER_D,
   output logic              LINK_UP,
   output logic [CNT_W-1:0]  UFLOW_CNT
);

   localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] TRAIN_N   = CNT_W'(TRAIN_WORDS);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_t           state;
   // In S_TRAIN, cnt holds the number of training words already placed on
   // OSER_D; entry from S_RUN starts at 0 because the first cycle there still
   // carries the last source word.
   logic [CNT_W-1:0] cnt;

   // prbs_req: PRBS requested this cycle (drives the next DATA_RDY)
   // prbs_act: PRBS active this cycle (registered request, selects OSER_D)
   logic       prbs_req;
   logic       prbs_act;
   logic [9:0] prbs_word;

`ifdef OSER10_CTRL_PRBS_EN
   logic prbs_q;
   logic run_entry;
   logic prbs_load;
   logic prbs_adv;

   assign prbs_req  = PRBS_MODE;
   assign prbs_act  = prbs_q;
   assign run_entry = ENABLE && (state == S_TRAIN) && !RETRAIN && (cnt == TRAIN_N);
   assign prbs_load = run_entry || (PRBS_MODE && !prbs_q);
   assign prbs_adv  = ENABLE && (state == S_RUN) && prbs_q;

   // Registered copy of PRBS_MODE for rise detection and output select
   always_ff @(posedge PCLK or posedge RESET) begin
      if (RESET) begin
         prbs_q <= 1'b0;
      end else begin
         prbs_q <= PRBS_MODE;
      end
   end

   oser10_prbs7 u_prbs (
      .clk  (PCLK),
      .rst  (RESET),
      .load (prbs_load),
      .adv  (prbs_adv),
      .word (prbs_word)
   );
`else
   assign prbs_req  = 1'b0;
   assign prbs_act  = 1'b0;
   assign prbs_word = '0;
`endif

   // Sequencer FSM with registered outputs; ENABLE low overrides everything
   always_ff @(posedge PCLK or posedge RESET) begin
      if (RESET) begin
         state     <= S_HOLD;
         cnt       <= '0;
         OSER_RST  <= 1'b1;
         OSER_D    <= '0;
         DATA_RDY  <= 1'b0;
         LINK_UP   <= 1'b0;
         UFLOW_CNT <= '0;
      end else if (!ENABLE) begin
         // RETRAIN is dropped here by construction
         state    <= S_HOLD;
         cnt      <= '0;
         OSER_RST <= 1'b1;
         OSER_D   <= '0;
         DATA_RDY <= 1'b0;
         LINK_UP  <= 1'b0;
      end else begin
         case (state)
            S_HOLD: begin
               if (cnt == RST_LAST) begin
                  state    <= S_WAIT;
                  cnt      <= '0;
                  OSER_RST <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end

            S_WAIT: begin
               if (cnt == WAIT_LAST) begin
                  state     <= S_TRAIN;
                  cnt       <= CNT_ONE;
                  OSER_D    <= TRAIN_WORD;
                  UFLOW_CNT <= '0;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end

            S_TRAIN: begin
               if (RETRAIN) begin
                  // restart the burst; this word is the first of the new count
                  cnt    <= CNT_ONE;
                  OSER_D <= TRAIN_WORD;
               end else if (cnt == TRAIN_N) begin
                  // nothing was accepted on this edge, so the first run word is idle
                  state    <= S_RUN;
                  cnt      <= '0;
                  OSER_D   <= IDLE_WORD;
                  DATA_RDY <= !prbs_req;
                  LINK_UP  <= 1'b1;
               end else begin
                  cnt    <= cnt + CNT_ONE;
                  OSER_D <= TRAIN_WORD;
               end
            end

            S_RUN: begin
               if (prbs_act) begin
                  OSER_D <= prbs_word;
               end else if (DATA_VLD && DATA_RDY) begin
                  OSER_D <= DATA;
               end else begin
                  OSER_D <= IDLE_WORD;
                  if (UFLOW_CNT != '1) begin
                     UFLOW_CNT <= UFLOW_CNT + CNT_ONE;
                  end
               end
               DATA_RDY <= !prbs_req;
               // the word chosen above still goes out; training follows it
               if (RETRAIN) begin
                  state     <= S_TRAIN;
                  cnt       <= '0;
                  DATA_RDY  <= 1'b0;
                  LINK_UP   <= 1'b0;
                  UFLOW_CNT <= '0;
               end
            end

            default: begin
               state <= S_HOLD;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_oser10_ctrl.sv
// tb_oser10_ctrl: scoreboard bench for oser10_ctrl (default parameters).
// Expected OSER_D words are queued as stimulus is driven and compared one
// clock later. PRBS checks are compiled in when OSER10_CTRL_PRBS_EN is defined.
module tb_oser10_ctrl;

   localparam int         RSTC = 16;
   localparam int         WAITC = 4;
   localparam int         TRN  = 64;
   localparam logic [9:0] TW   = 10'h3E0;
   localparam logic [9:0] IW   = 10'h354;

   logic        PCLK = 1'b0;
   logic        RESET;
   logic        ENABLE;
   logic        RETRAIN;
   logic [9:0]  DATA;
   logic        DATA_VLD;
   logic        DATA_RDY;
`ifdef OSER10_CTRL_PRBS_EN
   logic        PRBS_MODE;
`endif
   logic        OSER_RST;
   logic [9:0]  OSER_D;
   logic        LINK_UP;
   logic [15:0] UFLOW_CNT;

   int         n_chk = 0;
   int         n_err = 0;
   logic [9:0] exp_q[$];

   oser10_ctrl dut (
      .PCLK      (PCLK),
      .RESET     (RESET),
      .ENABLE    (ENABLE),
      .RETRAIN   (RETRAIN),
      .DATA      (DATA),
      .DATA_VLD  (DATA_VLD),
      .DATA_RDY  (DATA_RDY),
`ifdef OSER10_CTRL_PRBS_EN
      .PRBS_MODE (PRBS_MODE),
`endif
      .OSER_RST  (OSER_RST),
      .OSER_D    (OSER_D),
      .LINK_UP   (LINK_UP),
      .UFLOW_CNT (UFLOW_CNT)
   );

   always #5 PCLK = ~PCLK;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Drive one cycle of stimulus, queue the word expected after the edge, compare
   task automatic step(input logic vld, input logic [9:0] d, input logic rt,
                       input logic [9:0] exp_d, input string tag);
      DATA_VLD = vld;
      DATA     = d;
      RETRAIN  = rt;
      exp_q.push_back(exp_d);
      @(posedge PCLK);
      #1;
      RETRAIN = 1'b0;
      check(tag, {22'd0, OSER_D}, {22'd0, exp_q.pop_front()});
   endtask

   // Full link bring-up from a zeroed S_HOLD with ENABLE=1; stops after
   // train_stop training words when train_stop < TRN
   task automatic bringup(input int train_stop);
      DATA_VLD = 1'b0;
      for (int i = 1; i <= RSTC; i++) begin
         @(posedge PCLK);
         #1;
         check("oser_rst_hold", {31'd0, OSER_RST}, {31'd0, (i < RSTC)});
      end
      check("wait_d_first", {22'd0, OSER_D}, 32'd0);
      for (int i = 1; i < WAITC; i++) step(1'b0, 10'h0, 1'b0, 10'h000, "wait_d");
      for (int i = 0; i < train_stop; i++) step(1'b0, 10'h0, 1'b0, TW, "train_d");
      check("train_link", {31'd0, LINK_UP}, 32'd0);
      check("train_rdy", {31'd0, DATA_RDY}, 32'd0);
      if (train_stop == TRN) begin
         step(1'b0, 10'h0, 1'b0, IW, "run_first_d");
         check("run_link", {31'd0, LINK_UP}, 32'd1);
         check("run_rdy", {31'd0, DATA_RDY}, 32'd1);
         check("run_uflow", {16'd0, UFLOW_CNT}, 32'd0);
      end
   endtask

`ifdef OSER10_CTRL_PRBS_EN
   function automatic logic [9:0] prbs_ref(inout logic [6:0] s);
      logic [9:0] w;
      logic       fb;
      w = '0;
      for (int i = 0; i < 10; i++) begin
         fb   = s[6] ^ s[5];
         w[i] = fb;
         s    = {s[5:0], fb};
      end
      return w;
   endfunction
`endif

   initial begin
      RESET    = 1'b1;
      ENABLE   = 1'b1;
      RETRAIN  = 1'b0;
      DATA     = '0;
      DATA_VLD = 1'b0;
`ifdef OSER10_CTRL_PRBS_EN
      PRBS_MODE = 1'b0;
`endif
      repeat (2) @(posedge PCLK);
      #1;
      check("rst_oser_rst", {31'd0, OSER_RST}, 32'd1);
      check("rst_oser_d", {22'd0, OSER_D}, 32'd0);
      check("rst_rdy", {31'd0, DATA_RDY}, 32'd0);
      check("rst_link", {31'd0, LINK_UP}, 32'd0);
      check("rst_uflow", {16'd0, UFLOW_CNT}, 32'd0);
      RESET = 1'b0;
      bringup(TRN);

      // Streaming 0..9 back to back
      for (int i = 0; i < 10; i++) step(1'b1, 10'(i), 1'b0, 10'(i), "stream_d");
      check("stream_uflow", {16'd0, UFLOW_CNT}, 32'd0);
      check("stream_rdy", {31'd0, DATA_RDY}, 32'd1);

      // Underflow for 3 cycles
      for (int i = 0; i < 3; i++) step(1'b0, 10'h0AA, 1'b0, IW, "uflow_d");
      check("uflow_cnt3", {16'd0, UFLOW_CNT}, 32'd3);

      // Drive the counter to saturation, then underflow once more
      DATA_VLD = 1'b0;
      repeat (65532) @(posedge PCLK);
      #1;
      check("uflow_full", {16'd0, UFLOW_CNT}, 32'hFFFF);
      step(1'b0, 10'h0, 1'b0, IW, "uflow_sat_d");
      check("uflow_sat", {16'd0, UFLOW_CNT}, 32'hFFFF);
      step(1'b1, 10'h3FF, 1'b0, 10'h3FF, "post_sat_d");

      // Retrain together with an accepted word
      step(1'b1, 10'h155, 1'b1, 10'h155, "rt_word_d");
      check("rt_link", {31'd0, LINK_UP}, 32'd0);
      check("rt_rdy", {31'd0, DATA_RDY}, 32'd0);
      check("rt_uflow", {16'd0, UFLOW_CNT}, 32'd0);
      for (int i = 0; i < 10; i++) step(1'b1, 10'(i), 1'b0, TW, "rt_train_d");
      // Retrain during training restarts the count of 64
      step(1'b1, 10'h0, 1'b1, TW, "rt_restart_d");
      for (int i = 1; i < TRN; i++) step(1'b1, 10'(i), 1'b0, TW, "rt_train2_d");
      check("rt_train_link", {31'd0, LINK_UP}, 32'd0);
      step(1'b1, 10'h011, 1'b0, IW, "rt_exit_d");
      check("rt_exit_link", {31'd0, LINK_UP}, 32'd1);
      step(1'b1, 10'h22A, 1'b0, 10'h22A, "rt_stream_d");

      // ENABLE low and RETRAIN together: ENABLE wins
      ENABLE   = 1'b0;
      RETRAIN  = 1'b1;
      DATA_VLD = 1'b1;
      @(posedge PCLK);
      #1;
      RETRAIN  = 1'b0;
      check("dis_oser_rst", {31'd0, OSER_RST}, 32'd1);
      check("dis_oser_d", {22'd0, OSER_D}, 32'd0);
      check("dis_link", {31'd0, LINK_UP}, 32'd0);
      check("dis_rdy", {31'd0, DATA_RDY}, 32'd0);
      repeat (20) @(posedge PCLK);
      #1;
      check("dis_hold_rst", {31'd0, OSER_RST}, 32'd1);
      ENABLE = 1'b1;
      bringup(TRN);

      // Mid-training reset: outputs go to reset values with no clock edge
      ENABLE = 1'b0;
      @(posedge PCLK);
      #1;
      ENABLE = 1'b1;
      bringup(5);
      #2;
      RESET = 1'b1;
      #1;
      check("mid_oser_rst", {31'd0, OSER_RST}, 32'd1);
      check("mid_oser_d", {22'd0, OSER_D}, 32'd0);
      check("mid_link", {31'd0, LINK_UP}, 32'd0);
      @(posedge PCLK);
      #1;
      RESET = 1'b0;
      bringup(TRN);
      step(1'b1, 10'h0C3, 1'b0, 10'h0C3, "final_d");

`ifdef OSER10_CTRL_PRBS_EN
      begin
         logic [6:0] s;
         logic [9:0] w;
         logic [9:0] w0;
         s = 7'h7F;
         w0 = '0;
         PRBS_MODE = 1'b1;
         step(1'b1, 10'h011, 1'b0, 10'h011, "prbs_rise_d");
         check("prbs_rdy", {31'd0, DATA_RDY}, 32'd0);
         for (int k = 0; k < 128; k++) begin
            w = prbs_ref(s);
            step(1'b1, 10'h0, 1'b0, w, "prbs_d");
            if (k == 0) w0 = OSER_D;
         end
         check("prbs_period", {22'd0, OSER_D}, {22'd0, w0});
         check("prbs_uflow", {16'd0, UFLOW_CNT}, 32'd0);
         PRBS_MODE = 1'b0;
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   // Safety bound on total run time
   initial begin
      #5000000;
      n_chk++;
      n_err++;
      $display("FAIL timeout: got running expected finished");
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
